// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source for vga_core: follows frame_active/vert_active to track the
// active-pixel position and drives one registered colour per active pixel.
module vga_pattern_gen #(
    parameter int CHECKER_LOG2 = 5
) (
    input  logic        pxl_clk,
    input  logic        pxl_rst,
    input  logic [31:0] horz_res,
    input  logic [2:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    input  logic        vert_active,
    input  logic        frame_active,
    output logic [7:0]  rgb_red,
    output logic [7:0]  rgb_green,
    output logic [7:0]  rgb_blue,
    output logic [11:0] pxl_x,
    output logic [11:0] pxl_y,
    output logic [7:0]  frame_cnt,
    output logic        frame_start
);

    logic        fa_q;
    logic        va_q;
    logic        line_end;
    logic        frame_end;

    // sync | meaning
    // 0    | waiting for first vert_active fall, outputs blank
    // 1    | locked to frame timing, patterns enabled
    logic        sync;

    logic [2:0]  pattern_q;
    logic [23:0] solid_q;
    logic [11:0] bar_w;
    logic [11:0] x_cnt;
    logic [11:0] y_cnt;
    logic [11:0] bar_cnt;
    logic [2:0]  bar_idx;

    logic [31:0] hres_div;
    logic [11:0] bar_w_nxt;
    logic [23:0] bar_rgb;
    logic [23:0] pix_rgb;

    assign line_end  = fa_q & ~frame_active;
    assign frame_end = va_q & ~vert_active;

    assign hres_div  = horz_res >> 3;
    assign bar_w_nxt = (hres_div == 32'd0) ? 12'd1 : hres_div[11:0];

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase

        pix_rgb = 24'h000000;
        case (pattern_q)
            3'd0:    pix_rgb = solid_q;
            3'd1:    pix_rgb = bar_rgb;
            3'd2:    pix_rgb = (x_cnt[CHECKER_LOG2] ^ y_cnt[CHECKER_LOG2]) ? 24'hFFFFFF : 24'h000000;
            3'd3:    pix_rgb = {3{x_cnt[7:0]}};
            3'd4:    pix_rgb = {3{y_cnt[7:0]}};
            3'd5:    pix_rgb = {x_cnt[7:0] + frame_cnt, y_cnt[7:0], frame_cnt};
            default: pix_rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge pxl_clk) begin
        if (pxl_rst) begin
            fa_q        <= 1'b0;
            va_q        <= 1'b0;
            sync        <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
            pattern_q   <= 3'd0;
            solid_q     <= 24'h000000;
            bar_w       <= 12'd1;
            x_cnt       <= 12'd0;
            y_cnt       <= 12'd0;
            bar_cnt     <= 12'd0;
            bar_idx     <= 3'd0;
            pxl_x       <= 12'd0;
            pxl_y       <= 12'd0;
            rgb_red     <= 8'h00;
            rgb_green   <= 8'h00;
            rgb_blue    <= 8'h00;
        end else begin
            fa_q        <= frame_active;
            va_q        <= vert_active;
            frame_start <= frame_end;

            // Frame end takes priority over any concurrent line or pixel counting.
            if (frame_end) begin
                sync      <= 1'b1;
                if (sync)
                    frame_cnt <= frame_cnt + 8'd1;
                pattern_q <= pattern_sel;
                solid_q   <= solid_rgb;
                bar_w     <= bar_w_nxt;
                x_cnt     <= 12'd0;
                y_cnt     <= 12'd0;
                bar_cnt   <= 12'd0;
                bar_idx   <= 3'd0;
            end else if (sync) begin
                if (frame_active) begin
                    x_cnt <= x_cnt + 12'd1;
                    if (bar_cnt == bar_w - 12'd1) begin
                        bar_cnt <= 12'd0;
                        if (bar_idx != 3'd7)
                            bar_idx <= bar_idx + 3'd1;
                    end else begin
                        bar_cnt <= bar_cnt + 12'd1;
                    end
                end else if (line_end) begin
                    x_cnt   <= 12'd0;
                    bar_cnt <= 12'd0;
                    bar_idx <= 3'd0;
                    y_cnt   <= y_cnt + 12'd1;
                end
            end

            if (sync && frame_active) begin
                {rgb_red, rgb_green, rgb_blue} <= pix_rgb;
                pxl_x <= x_cnt;
                pxl_y <= y_cnt;
            end else begin
                {rgb_red, rgb_green, rgb_blue} <= 24'h000000;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed and randomized frame sequences for vga_pattern_gen; expected pixels come from
// loop coordinates and the pattern definitions, checked one cycle after each drive.
module tb_vga_pattern_gen;

    localparam int CHK = 5;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        pxl_clk = 1'b0;
    logic        pxl_rst;
    logic [31:0] horz_res;
    logic [2:0]  pattern_sel;
    logic [23:0] solid_rgb;
    logic        vert_active;
    logic        frame_active;
    logic [7:0]  rgb_red;
    logic [7:0]  rgb_green;
    logic [7:0]  rgb_blue;
    logic [11:0] pxl_x;
    logic [11:0] pxl_y;
    logic [7:0]  frame_cnt;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // reference state: what the generator should have latched for the current frame
    bit          synced_m;
    int          fcnt_m;
    int          sel_m;
    logic [23:0] solid_m;
    int          bw_m;
    bit          va_m;

    vga_pattern_gen #(.CHECKER_LOG2(CHK)) dut (
        .pxl_clk      (pxl_clk),
        .pxl_rst      (pxl_rst),
        .horz_res     (horz_res),
        .pattern_sel  (pattern_sel),
        .solid_rgb    (solid_rgb),
        .vert_active  (vert_active),
        .frame_active (frame_active),
        .rgb_red      (rgb_red),
        .rgb_green    (rgb_green),
        .rgb_blue     (rgb_blue),
        .pxl_x        (pxl_x),
        .pxl_y        (pxl_y),
        .frame_cnt    (frame_cnt),
        .frame_start  (frame_start)
    );

    always #5 pxl_clk = ~pxl_clk;

    function automatic logic [23:0] pat(input int x, input int y);
        int idx;
        case (sel_m)
            0: return solid_m;
            1: begin
                idx = x / bw_m;
                if (idx > 7) idx = 7;
                return BARS[idx];
            end
            2: return ((((x >> CHK) ^ (y >> CHK)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
            3: return {3{8'(x % 256)}};
            4: return {3{8'(y % 256)}};
            5: return {8'((x + fcnt_m) % 256), 8'(y % 256), 8'(fcnt_m % 256)};
            default: return 24'h000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, let the edge sample them, check the registered result.
    task automatic cyc(input logic fa, input logic va, input int x, input int y, input logic rst);
        logic        fe;
        logic        pix;
        logic [23:0] exp_rgb;
        logic [31:0] d;
        frame_active = fa;
        vert_active  = va;
        pxl_rst      = rst;
        fe      = !rst && va_m && !va;
        pix     = !rst && synced_m && fa;
        exp_rgb = pix ? pat(x, y) : 24'h000000;
        @(posedge pxl_clk);
        #1;
        if (rst) begin
            synced_m = 0; fcnt_m = 0; sel_m = 0; solid_m = 24'h0; bw_m = 1; va_m = 0;
        end else begin
            if (fe) begin
                if (synced_m) fcnt_m = (fcnt_m + 1) % 256;
                synced_m = 1;
                sel_m    = int'(pattern_sel);
                solid_m  = solid_rgb;
                d        = horz_res >> 3;
                bw_m     = (d == 0) ? 1 : int'(d & 32'hFFF);
            end
            va_m = va;
        end
        chk("rgb", {8'h00, rgb_red, rgb_green, rgb_blue}, {8'h00, exp_rgb});
        chk("frame_start", {31'd0, frame_start}, {31'd0, fe});
        chk("frame_cnt", {24'd0, frame_cnt}, 32'(fcnt_m));
        if (pix || rst) begin
            chk("pxl_x", {20'd0, pxl_x}, rst ? 32'd0 : 32'(x));
            chk("pxl_y", {20'd0, pxl_y}, rst ? 32'd0 : 32'(y));
        end
        pxl_rst = 1'b0;
    endtask

    // One frame: lines of h active pixels plus horizontal blank, then vertical blank.
    // Next-frame settings are applied just before the vert_active fall that latches them.
    task automatic frame(input int lines, input int h, input int chg_line, input logic [2:0] chg_sel,
                         input int rst_line, input logic [2:0] nsel, input logic [23:0] nsolid,
                         input logic [31:0] nhres);
        int hb;
        int vb;
        hb = $urandom_range(4, 1);
        vb = $urandom_range(5, 2);
        for (int y = 0; y < lines; y++) begin
            if (y == chg_line) begin
                pattern_sel = chg_sel;
                solid_rgb   = 24'($urandom);
                horz_res    = 32'($urandom_range(400, 8));
            end
            if (y == rst_line) cyc(1'b0, 1'b1, 0, y, 1'b1);
            for (int x = 0; x < h; x++) cyc(1'b1, 1'b1, x, y, 1'b0);
            for (int i = 0; i < hb; i++) cyc(1'b0, 1'b1, 0, y, 1'b0);
        end
        pattern_sel = nsel;
        solid_rgb   = nsolid;
        horz_res    = nhres;
        for (int i = 0; i < vb; i++) cyc(1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        pxl_rst      = 1'b1;
        horz_res     = 32'd640;
        pattern_sel  = 3'd1;
        solid_rgb    = 24'h0;
        vert_active  = 1'b0;
        frame_active = 1'b0;
        synced_m = 0; fcnt_m = 0; sel_m = 0; solid_m = 24'h0; bw_m = 1; va_m = 0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 0, 0, 1'b1);

        // unsynced frame stays blank, then 640-wide colour bars (80 px per bar)
        frame(3, 8, -1, 3'd0, -1, 3'd1, 24'h0, 32'd640);
        frame(2, 640, -1, 3'd0, -1, 3'd2, 24'h0, 32'd40);
        // checkerboard with 32-pixel squares
        frame(40, 40, -1, 3'd0, -1, 3'd0, 24'h123456, 32'd40);
        // solid frame with a mid-frame select change that must wait for the next frame
        frame(30, 12, 20, 3'd3, -1, 3'd3, 24'h0, 32'd12);
        frame(4, 10, -1, 3'd0, -1, 3'd5, 24'h0, 32'd10);
        // reset in mid-frame: blank, resync, then frame_cnt restarts from zero
        frame(30, 8, -1, 3'd0, 12, 3'd5, 24'h0, 32'd8);
        frame(3, 8, -1, 3'd0, -1, 3'd5, 24'h0, 32'd8);
        frame(3, 8, -1, 3'd0, -1, 3'd5, 24'h0, 32'd8);
        frame(3, 8, -1, 3'd0, -1, 3'd5, 24'h0, 32'd8);
        frame(3, 8, -1, 3'd0, -1, 3'd1, 24'h0, 32'd4);
        // horz_res 4 gives one-pixel bars, index saturates at black
        frame(2, 12, -1, 3'd0, -1, 3'($urandom_range(7, 0)), 24'($urandom), 32'($urandom_range(300, 1)));

        for (int f = 0; f < 10; f++) begin
            frame($urandom_range(12, 2), $urandom_range(300, 4),
                  ($urandom_range(1, 0) == 1) ? $urandom_range(2, 0) : -1, 3'($urandom_range(7, 0)),
                  -1, 3'($urandom_range(7, 0)), 24'($urandom), 32'($urandom_range(2500, 0)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
